// File: rtl/usb_pkg.sv
// Shared definitions for the USB byte-path controllers.
// Provides default sizing and the one-hot push-FSM state encoding.
// No ports; imported by byte_rx_control and rx_hold_fifo.
package usb_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_HOLD_DEPTH   = 4;
  localparam int DEF_IDLE_TIMEOUT = 1000;
  localparam int DEF_CNT_W        = 16;

  // One-hot, same style as the tx-side pop/send controller.
  typedef enum logic [1:0] {
    S_RX_IDLE = 2'b01,
    S_RX_PUSH = 2'b10
  } rx_state_e;

endpackage

// File: rtl/rx_hold_fifo.sv
// Holding queue: DEPTH x DATA_W circular buffer, pointers carry an extra wrap bit.
// Latency: write visible on dout/empty the cycle after wr; dout is the current head (show-ahead).
// Backpressure: wr ignored when full unless rd in the same cycle; rd ignored when empty.
// Ports: clk, rst_n, wr/din (tail write), rd (head pop), dout (head), full, empty.
module rx_hold_fifo
  import usb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_HOLD_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic              rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_en = rd & ~empty;
  // A pop frees the head slot in the same cycle, so a full queue can still take a write.
  assign wr_en = wr & (~full | rd_en);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + (AW+1)'(1);
      if (rd_en) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/byte_rx_control.sv
// Rx byte-path controller: byte strobes -> holding queue -> rx FIFO push, packet-end and drop accounting.
// Latency: strobe in cycle N with empty queue and FIFO not full -> rx_fifo_push in N+1 (queue bypassed).
// Backpressure: rx_fifo_full stalls pushes; holding queue absorbs HOLD_DEPTH bytes, then overflow-drops.
// Ports: byte_rx_done/data/err from the byte receiver, rx_fifo_full/push/din to the rx FIFO,
//        clr_status, and status outputs rx_pkt_end, rx_overflow, rx_frame_err, rx_drop_cnt.
module byte_rx_control
  import usb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int HOLD_DEPTH   = DEF_HOLD_DEPTH,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_rx_done,
  input  logic [DATA_W-1:0] byte_rx_data,
  input  logic              byte_rx_err,
  input  logic              rx_fifo_full,
  input  logic              clr_status,
  output logic              rx_fifo_push,
  output logic [DATA_W-1:0] rx_fifo_din,
  output logic              rx_pkt_end,
  output logic              rx_overflow,
  output logic              rx_frame_err,
  output logic [CNT_W-1:0]  rx_drop_cnt
);

  localparam int              TW      = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0]   T_MAX   = TW'(IDLE_TIMEOUT);
  localparam logic [TW-1:0]   T_LAST  = TW'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rx_state_e         state;
  logic [TW-1:0]     gap_timer;
  logic              pkt_pending;

  logic              q_full;
  logic              q_empty;
  logic [DATA_W-1:0] q_head;

  logic              in_vld;
  logic              do_push;
  logic              q_rd;
  logic              bypass;
  logic              q_wr;
  logic              ovf_drop;
  logic              frm_drop;
  logic              drop;
  logic [DATA_W-1:0] push_dat;

  assign in_vld   = byte_rx_done & ~byte_rx_err;
  assign frm_drop = byte_rx_done &  byte_rx_err;
  // Something is pushable if the queue holds a byte or a good byte arrives right now.
  assign do_push  = (~q_empty | in_vld) & ~rx_fifo_full;
  assign q_rd     = do_push & ~q_empty;
  // Empty queue: the arriving byte goes straight to rx_fifo_din, saving a cycle.
  assign bypass   = in_vld & q_empty & do_push;
  assign ovf_drop = in_vld & q_full & ~q_rd;
  assign q_wr     = in_vld & ~bypass & ~ovf_drop;
  assign drop     = ovf_drop | frm_drop;
  assign push_dat = q_empty ? byte_rx_data : q_head;

  rx_hold_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (HOLD_DEPTH)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (q_wr),
    .din   (byte_rx_data),
    .rd    (q_rd),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // Push FSM: one push per cycle while data is available and the FIFO has room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_RX_IDLE;
      rx_fifo_push <= 1'b0;
      rx_fifo_din  <= '0;
    end else begin
      case (state)
        S_RX_IDLE: begin
          rx_fifo_push <= do_push;
          if (do_push) begin
            rx_fifo_din <= push_dat;
            state       <= S_RX_PUSH;
          end
        end
        S_RX_PUSH: begin
          rx_fifo_push <= do_push;
          if (do_push) rx_fifo_din <= push_dat;
          else         state       <= S_RX_IDLE;
        end
        default: begin
          rx_fifo_push <= 1'b0;
          state        <= S_RX_IDLE;
        end
      endcase
    end
  end

  // Gap timer counts cycles elapsed since the last good (accepted or overflowed) strobe:
  // it reads 1 in the cycle after the strobe, so the pulse lands IDLE_TIMEOUT cycles after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_timer   <= '0;
      pkt_pending <= 1'b0;
      rx_pkt_end  <= 1'b0;
    end else begin
      rx_pkt_end <= 1'b0;
      if (in_vld) begin
        gap_timer   <= TW'(1);
        pkt_pending <= 1'b1;
      end else begin
        if (gap_timer != T_MAX) gap_timer <= gap_timer + TW'(1);
        if (pkt_pending && gap_timer == T_LAST) begin
          rx_pkt_end  <= 1'b1;
          pkt_pending <= 1'b0;
        end
      end
    end
  end

  // Sticky status; a drop coinciding with clr_status is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_drop_cnt  <= '0;
    end else if (clr_status) begin
      rx_overflow  <= ovf_drop;
      rx_frame_err <= frm_drop;
      rx_drop_cnt  <= drop ? CNT_W'(1) : '0;
    end else begin
      if (ovf_drop) rx_overflow  <= 1'b1;
      if (frm_drop) rx_frame_err <= 1'b1;
      if (drop && rx_drop_cnt != CNT_MAX) rx_drop_cnt <= rx_drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_byte_rx_control.sv
// Bench for byte_rx_control: directed scenarios plus a random phase, checked every cycle
// against a queue-based reference model. A second instance with CNT_W=4 shares the stimulus.
module tb_byte_rx_control;

  localparam int T = 1000;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       byte_rx_done = 1'b0;
  logic [7:0] byte_rx_data = 8'h00;
  logic       byte_rx_err  = 1'b0;
  logic       rx_fifo_full = 1'b0;
  logic       clr_status   = 1'b0;

  logic        rx_fifo_push, rx_pkt_end, rx_overflow, rx_frame_err;
  logic [7:0]  rx_fifo_din;
  logic [15:0] rx_drop_cnt;
  logic        push4, end4, ovf4, ferr4;
  logic [7:0]  din4;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  byte_rx_control dut (
    .clk(clk), .rst_n(rst_n), .byte_rx_done(byte_rx_done), .byte_rx_data(byte_rx_data),
    .byte_rx_err(byte_rx_err), .rx_fifo_full(rx_fifo_full), .clr_status(clr_status),
    .rx_fifo_push(rx_fifo_push), .rx_fifo_din(rx_fifo_din), .rx_pkt_end(rx_pkt_end),
    .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err), .rx_drop_cnt(rx_drop_cnt)
  );

  byte_rx_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .byte_rx_done(byte_rx_done), .byte_rx_data(byte_rx_data),
    .byte_rx_err(byte_rx_err), .rx_fifo_full(rx_fifo_full), .clr_status(clr_status),
    .rx_fifo_push(push4), .rx_fifo_din(din4), .rx_pkt_end(end4),
    .rx_overflow(ovf4), .rx_frame_err(ferr4), .rx_drop_cnt(cnt4)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       e_push, e_end, e_ovf, e_ferr;
  logic [7:0] e_din;
  int         e_cnt, e_cnt4;
  bit         pend;
  int         cyc = 0;
  int         strobe_cyc = 0;

  // Observation bookkeeping
  int         pushes = 0;
  int         ends = 0;
  int         end_cyc = -1;
  logic [7:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    e_push = 1'b0; e_din = 8'h00; e_end = 1'b0;
    e_ovf = 1'b0; e_ferr = 1'b0; e_cnt = 0; e_cnt4 = 0; pend = 1'b0;
  endtask

  // One clock edge of behaviour: bytes waiting = queue contents plus the arriving byte;
  // one leaves per cycle when the FIFO has room; at most D may remain waiting.
  task automatic model_edge();
    bit inv, ferr, pop, acc, ovf, drop;
    if (!rst_n) begin
      model_reset();
    end else begin
      inv  = byte_rx_done && !byte_rx_err;
      ferr = byte_rx_done && byte_rx_err;
      pop  = (q.size() > 0 || inv) && !rx_fifo_full;
      acc  = inv && (q.size() < D || pop);
      ovf  = inv && !acc;
      drop = ovf || ferr;
      if (acc) q.push_back(byte_rx_data);
      e_push = pop;
      if (pop) e_din = q.pop_front();
      if (inv) begin pend = 1'b1; strobe_cyc = cyc; end
      e_end = 1'b0;
      if (pend && (cyc + 1 - strobe_cyc) == T) begin e_end = 1'b1; pend = 1'b0; end
      if (clr_status) begin
        e_ovf = ovf; e_ferr = ferr;
        e_cnt = drop ? 1 : 0; e_cnt4 = drop ? 1 : 0;
      end else begin
        e_ovf  = e_ovf | ovf;
        e_ferr = e_ferr | ferr;
        if (drop && e_cnt < 65535) e_cnt++;
        if (drop && e_cnt4 < 15) e_cnt4++;
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    chk("push", 32'(rx_fifo_push), 32'(e_push));
    chk("din", 32'(rx_fifo_din), 32'(e_din));
    chk("pkt_end", 32'(rx_pkt_end), 32'(e_end));
    chk("overflow", 32'(rx_overflow), 32'(e_ovf));
    chk("frame_err", 32'(rx_frame_err), 32'(e_ferr));
    chk("drop_cnt", 32'(rx_drop_cnt), 32'(e_cnt));
    chk("push4", 32'(push4), 32'(e_push));
    chk("din4", 32'(din4), 32'(e_din));
    chk("pkt_end4", 32'(end4), 32'(e_end));
    chk("overflow4", 32'(ovf4), 32'(e_ovf));
    chk("frame_err4", 32'(ferr4), 32'(e_ferr));
    chk("drop_cnt4", 32'(cnt4), 32'(e_cnt4));
    if (rx_fifo_push) begin pushes++; got.push_back(rx_fifo_din); end
    if (rx_pkt_end) begin ends++; end_cyc = cyc; end
  endtask

  task automatic step(input bit d, input logic [7:0] b, input bit e, input bit c);
    byte_rx_done = d; byte_rx_data = b; byte_rx_err = e; clr_status = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int s;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_push", 32'(rx_fifo_push), 32'd0);
    chk("rst_din", 32'(rx_fifo_din), 32'd0);
    chk("rst_end", 32'(rx_pkt_end), 32'd0);
    chk("rst_ovf", 32'(rx_overflow), 32'd0);
    chk("rst_ferr", 32'(rx_frame_err), 32'd0);
    chk("rst_cnt", 32'(rx_drop_cnt), 32'd0);
    idle(2);
    rst_n = 1'b1;

    // Single byte: push next cycle, packet end exactly T cycles after the strobe.
    s = cyc;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("t1_push", 32'(rx_fifo_push), 32'd1);
    chk("t1_din", 32'(rx_fifo_din), 32'hA5);
    idle(T + 5);
    chk("t1_end_delay", 32'(end_cyc - s), 32'(T));

    // FIFO full for 20 cycles while 4 bytes arrive; then drained back-to-back in order.
    rx_fifo_full = 1'b1;
    pushes = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(i + 1), 1'b0, 1'b0);
      idle(1);
    end
    idle(12);
    chk("t2_no_push_full", 32'(pushes), 32'd0);
    rx_fifo_full = 1'b0;
    got.delete();
    idle(6);
    chk("t2_push_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t2_order", 32'(got[i]), 32'(i + 1));
    chk("t2_no_drop", 32'(rx_drop_cnt), 32'd0);

    // Holding overflow: 6 bytes against a full FIFO, 4 kept, 2 dropped.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    rx_fifo_full = 1'b1;
    repeat (6) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("t3_overflow", 32'(rx_overflow), 32'd1);
    chk("t3_cnt", 32'(rx_drop_cnt), 32'd2);
    pushes = 0;
    rx_fifo_full = 1'b0;
    idle(8);
    chk("t3_pushes", 32'(pushes), 32'd4);

    // Framing error: dropped, flagged, never arms packet end.
    idle(T + 10);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    ends = 0;
    pushes = 0;
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("t4_ferr", 32'(rx_frame_err), 32'd1);
    chk("t4_cnt", 32'(rx_drop_cnt), 32'd1);
    idle(T + 10);
    chk("t4_no_push", 32'(pushes), 32'd0);
    chk("t4_no_end", 32'(ends), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t4_clr_ferr", 32'(rx_frame_err), 32'd0);
    chk("t4_clr_cnt", 32'(rx_drop_cnt), 32'd0);
    step(1'b1, 8'($urandom), 1'b1, 1'b1);
    chk("t4_clr_drop_cnt", 32'(rx_drop_cnt), 32'd1);
    chk("t4_clr_drop_ferr", 32'(rx_frame_err), 32'd1);

    // Counter saturation on the 4-bit instance.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (20) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    chk("t5_cnt4_sat", 32'(cnt4), 32'd15);
    chk("t5_cnt16", 32'(rx_drop_cnt), 32'd20);

    // Asynchronous reset with bytes held: everything clears at once, queue contents lost.
    rx_fifo_full = 1'b1;
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_push", 32'(rx_fifo_push), 32'd0);
    chk("t6_rst_din", 32'(rx_fifo_din), 32'd0);
    chk("t6_rst_ferr", 32'(rx_frame_err), 32'd0);
    chk("t6_rst_cnt", 32'(rx_drop_cnt), 32'd0);
    model_reset();
    rx_fifo_full = 1'b0;
    idle(2);
    rst_n = 1'b1;
    pushes = 0;
    idle(5);
    chk("t6_no_push", 32'(pushes), 32'd0);
    step(1'b1, 8'h7E, 1'b0, 1'b0);
    chk("t6_push", 32'(rx_fifo_push), 32'd1);
    chk("t6_din", 32'(rx_fifo_din), 32'h7E);

    // Random traffic, errors, FIFO backpressure and clears.
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) rx_fifo_full = ~rx_fifo_full;
      step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 31) == 0);
    end
    rx_fifo_full = 1'b0;
    idle(T + 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
